// File: rtl/hazard_control_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : hazard_control_unit_if
// Brief    : Pipeline-to-hazard-controller signal bundle. The slave modport
//            is the hazard controller; the master modport is the pipeline.
// Revision : 1.0  initial release
// ============================================================================
interface hazard_control_unit_if #(
    parameter int CNT_W = 32
);
    // Register addresses per stage
    logic [4:0]       Rs1D, Rs2D;
    logic [4:0]       Rs1E, Rs2E, RdE;
    logic [4:0]       RdM, RdW;
    // Per-stage control
    logic             RegWriteE, RegWriteM, RegWriteW;
    logic             ResultSrcE;
    logic             PCSrcE;
    logic             MulDivE;
    logic             MdDone;
    // Hazard controller results
    logic [1:0]       ForwardA_E, ForwardB_E;
    logic             StallF, StallD, StallE;
    logic             FlushD, FlushE;
    logic             BubbleM;
    logic             MdStart, MdBusy, MdError;
    logic [CNT_W-1:0] StallCnt, FlushCnt;

    modport slave (
        input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
        input  RegWriteE, RegWriteM, RegWriteW, ResultSrcE, PCSrcE, MulDivE, MdDone,
        output ForwardA_E, ForwardB_E, StallF, StallD, StallE, FlushD, FlushE,
        output BubbleM, MdStart, MdBusy, MdError, StallCnt, FlushCnt
    );

    modport master (
        output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
        output RegWriteE, RegWriteM, RegWriteW, ResultSrcE, PCSrcE, MulDivE, MdDone,
        input  ForwardA_E, ForwardB_E, StallF, StallD, StallE, FlushD, FlushE,
        input  BubbleM, MdStart, MdBusy, MdError, StallCnt, FlushCnt
    );
endinterface
`default_nettype wire

// File: rtl/hazard_control_unit.sv
`default_nettype none
// ============================================================================
// Module   : hazard_control_unit
// Brief    : Forwarding selects, load-use stall, branch flush and mul/div
//            sequencing (IDLE/BUSY with timeout) for the 5-stage pipeline.
//            Optional macro HAZARD_PERF_CNT_EN enables the saturating
//            stall/flush performance counters (tied to 0 otherwise).
// Revision : 1.0  initial release
// ============================================================================
module hazard_control_unit #(
    parameter int MD_TIMEOUT = 64,
    parameter int CNT_W      = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    hazard_control_unit_if.slave hz
);

    localparam int                c_TO_W    = $clog2(MD_TIMEOUT);
    localparam logic [c_TO_W-1:0] c_TO_LAST = c_TO_W'(MD_TIMEOUT - 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_nextState;
    logic [c_TO_W-1:0] r_toCnt;
    logic              r_mdError;

    logic       w_lwStall;
    logic [1:0] w_fwdA, w_fwdB;
    logic       w_stallF, w_stallD, w_stallE;
    logic       w_flushD, w_flushE, w_bubbleM;
    logic       w_mdStart, w_mdBusy, w_setError;

    // M stage wins over W stage; x0 is never a forwarding source
    function automatic logic [1:0] fwdSel(
        input logic [4:0] rs,
        input logic       regWriteM,
        input logic [4:0] rdM,
        input logic       regWriteW,
        input logic [4:0] rdW
    );
        if (regWriteM && (rdM != 5'd0) && (rdM == rs))
            return 2'b10;
        else if (regWriteW && (rdW != 5'd0) && (rdW == rs))
            return 2'b01;
        else
            return 2'b00;
    endfunction

    // Forwarding selects and load-use detection, zero latency
    always_comb begin
        w_fwdA    = fwdSel(hz.Rs1E, hz.RegWriteM, hz.RdM, hz.RegWriteW, hz.RdW);
        w_fwdB    = fwdSel(hz.Rs2E, hz.RegWriteM, hz.RdM, hz.RegWriteW, hz.RdW);
        w_lwStall = hz.ResultSrcE && hz.RegWriteE && (hz.RdE != 5'd0) &&
                    ((hz.RdE == hz.Rs1D) || (hz.RdE == hz.Rs2D));
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_nextState;
    end

    // Next state and hazard controls; branches beat load-use and mul/div
    // issue, and BUSY ignores everything except completion and timeout
    always_comb begin
        w_nextState = r_state;
        w_stallF    = 1'b0;
        w_stallD    = 1'b0;
        w_stallE    = 1'b0;
        w_flushD    = 1'b0;
        w_flushE    = 1'b0;
        w_bubbleM   = 1'b0;
        w_mdStart   = 1'b0;
        w_mdBusy    = 1'b0;
        w_setError  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (hz.PCSrcE) begin
                    // The dependent/mul-div instruction is squashed anyway
                    w_flushD = 1'b1;
                    w_flushE = 1'b1;
                end else if (hz.MulDivE) begin
                    // Front end already frozen, so a coincident load-use needs no flush
                    w_mdStart   = 1'b1;
                    w_stallF    = 1'b1;
                    w_stallD    = 1'b1;
                    w_stallE    = 1'b1;
                    w_bubbleM   = 1'b1;
                    w_nextState = S_BUSY;
                end else if (w_lwStall) begin
                    w_stallF = 1'b1;
                    w_stallD = 1'b1;
                    w_flushE = 1'b1;
                end
            end
            S_BUSY: begin
                w_mdBusy = 1'b1;
                if (hz.MdDone) begin
                    // Release this cycle so the result moves to M at the next edge
                    w_nextState = S_IDLE;
                end else if (r_toCnt == c_TO_LAST) begin
                    w_setError  = 1'b1;
                    w_nextState = S_IDLE;
                end else begin
                    w_stallF  = 1'b1;
                    w_stallD  = 1'b1;
                    w_stallE  = 1'b1;
                    w_bubbleM = 1'b1;
                end
            end
            default: w_nextState = S_IDLE;
        endcase
    end

    // Timeout counter: zero while idle, counts every BUSY cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                  r_toCnt <= '0;
        else if (r_state == S_IDLE) r_toCnt <= '0;
        else                       r_toCnt <= r_toCnt + 1'b1;
    end

    // Sticky timeout flag, cleared only by reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)            r_mdError <= 1'b0;
        else if (w_setError) r_mdError <= 1'b1;
    end

    // Every output reads 0 while reset is held, even the combinational ones
    assign hz.ForwardA_E = rst ? w_fwdA : 2'b00;
    assign hz.ForwardB_E = rst ? w_fwdB : 2'b00;
    assign hz.StallF     = rst & w_stallF;
    assign hz.StallD     = rst & w_stallD;
    assign hz.StallE     = rst & w_stallE;
    assign hz.FlushD     = rst & w_flushD;
    assign hz.FlushE     = rst & w_flushE;
    assign hz.BubbleM    = rst & w_bubbleM;
    assign hz.MdStart    = rst & w_mdStart;
    assign hz.MdBusy     = rst & w_mdBusy;
    assign hz.MdError    = r_mdError;

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] r_stallCnt, r_flushCnt;

    // Saturating performance counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stallCnt <= '0;
            r_flushCnt <= '0;
        end else begin
            if (w_stallF && (r_stallCnt != {CNT_W{1'b1}}))
                r_stallCnt <= r_stallCnt + CNT_W'(1);
            if ((w_flushD || w_flushE) && (r_flushCnt != {CNT_W{1'b1}}))
                r_flushCnt <= r_flushCnt + CNT_W'(1);
        end
    end

    assign hz.StallCnt = r_stallCnt;
    assign hz.FlushCnt = r_flushCnt;
`else
    assign hz.StallCnt = '0;
    assign hz.FlushCnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_control_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_control_unit
// Brief    : Directed self-checking bench for hazard_control_unit
//            (MD_TIMEOUT=8). Control outputs are checked as one vector
//            {StallF,StallD,StallE,FlushD,FlushE,BubbleM,MdStart,MdBusy}.
// Revision : 1.0  initial release
// ============================================================================
module tb_hazard_control_unit;
    localparam int MD_TIMEOUT = 8;
    localparam int CNT_W      = 32;

    localparam logic [7:0] c_NONE  = 8'b0000_0000;
    localparam logic [7:0] c_LU    = 8'b1100_1000;
    localparam logic [7:0] c_BR    = 8'b0001_1000;
    localparam logic [7:0] c_START = 8'b1110_0110;
    localparam logic [7:0] c_BUSY  = 8'b1110_0101;
    localparam logic [7:0] c_REL   = 8'b0000_0001;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   tests = 0;
    int   fails = 0;
    logic [CNT_W-1:0] expStall = '0;
    logic [CNT_W-1:0] expFlush = '0;
    logic [7:0] ctrl;

    hazard_control_unit_if #(.CNT_W(CNT_W)) hzIf();

    hazard_control_unit #(.MD_TIMEOUT(MD_TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .hz  (hzIf)
    );

    always #5 clk = ~clk;

    assign ctrl = {hzIf.StallF, hzIf.StallD, hzIf.StallE, hzIf.FlushD,
                   hzIf.FlushE, hzIf.BubbleM, hzIf.MdStart, hzIf.MdBusy};

    task automatic clear_inputs();
        hzIf.Rs1D = 0; hzIf.Rs2D = 0; hzIf.Rs1E = 0; hzIf.Rs2E = 0; hzIf.RdE = 0;
        hzIf.RdM = 0; hzIf.RdW = 0;
        hzIf.RegWriteE = 0; hzIf.RegWriteM = 0; hzIf.RegWriteW = 0;
        hzIf.ResultSrcE = 0; hzIf.PCSrcE = 0; hzIf.MulDivE = 0; hzIf.MdDone = 0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b0;
        // Inputs that would forward, load-use stall and start mul/div
        hzIf.RdM = 5; hzIf.Rs1E = 5; hzIf.Rs2E = 5; hzIf.RegWriteM = 1;
        hzIf.ResultSrcE = 1; hzIf.RegWriteE = 1; hzIf.RdE = 3; hzIf.Rs1D = 3;
        hzIf.MulDivE = 1;
        #1;
        tests++; if (hzIf.ForwardA_E !== 2'b00) begin fails++; $display("FAIL rst_fwdA got=%b exp=00", hzIf.ForwardA_E); end
        tests++; if (hzIf.ForwardB_E !== 2'b00) begin fails++; $display("FAIL rst_fwdB got=%b exp=00", hzIf.ForwardB_E); end
        tests++; if (ctrl !== c_NONE) begin fails++; $display("FAIL rst_ctrl got=%b exp=%b", ctrl, c_NONE); end
        tests++; if (hzIf.MdError !== 1'b0) begin fails++; $display("FAIL rst_err got=%b exp=0", hzIf.MdError); end
        tests++; if (hzIf.StallCnt !== '0 || hzIf.FlushCnt !== '0) begin fails++; $display("FAIL rst_cnt got=%0d/%0d exp=0/0", hzIf.StallCnt, hzIf.FlushCnt); end
        @(negedge clk); clear_inputs(); rst = 1'b1;
        @(negedge clk); #1;
        tests++; if (ctrl !== c_NONE) begin fails++; $display("FAIL rst_rel_ctrl got=%b exp=%b", ctrl, c_NONE); end
    endtask

    task automatic test_forward();
        @(negedge clk); clear_inputs();
        hzIf.RdM = 5; hzIf.RdW = 5; hzIf.Rs1E = 5; hzIf.Rs2E = 5;
        hzIf.RegWriteM = 1; hzIf.RegWriteW = 1; #1;
        tests++; if (hzIf.ForwardA_E !== 2'b10) begin fails++; $display("FAIL fwd_prio_A got=%b exp=10", hzIf.ForwardA_E); end
        tests++; if (hzIf.ForwardB_E !== 2'b10) begin fails++; $display("FAIL fwd_prio_B got=%b exp=10", hzIf.ForwardB_E); end
        hzIf.RegWriteM = 0; #1;
        tests++; if (hzIf.ForwardA_E !== 2'b01) begin fails++; $display("FAIL fwd_w_A got=%b exp=01", hzIf.ForwardA_E); end
        hzIf.RegWriteM = 1; hzIf.Rs1E = 0; hzIf.RdM = 0; hzIf.RdW = 0; hzIf.Rs2E = 0; #1;
        tests++; if ({hzIf.ForwardA_E, hzIf.ForwardB_E} !== 4'b0000) begin fails++; $display("FAIL fwd_x0 got=%b%b exp=0000", hzIf.ForwardA_E, hzIf.ForwardB_E); end
        // Independent sources: A from M, B from W
        hzIf.RdM = 3; hzIf.RdW = 4; hzIf.Rs1E = 3; hzIf.Rs2E = 4; #1;
        tests++; if ({hzIf.ForwardA_E, hzIf.ForwardB_E} !== 4'b1001) begin fails++; $display("FAIL fwd_split got=%b%b exp=1001", hzIf.ForwardA_E, hzIf.ForwardB_E); end
        hzIf.RegWriteW = 0; #1;
        tests++; if (hzIf.ForwardB_E !== 2'b00) begin fails++; $display("FAIL fwd_nowr_B got=%b exp=00", hzIf.ForwardB_E); end
        tests++; if (ctrl !== c_NONE) begin fails++; $display("FAIL fwd_ctrl got=%b exp=%b", ctrl, c_NONE); end
    endtask

    task automatic test_load_use();
        @(negedge clk); clear_inputs();
        hzIf.ResultSrcE = 1; hzIf.RegWriteE = 1; hzIf.RdE = 7; hzIf.Rs2D = 7; #1;
        tests++; if (ctrl !== c_LU) begin fails++; $display("FAIL lu_ctrl got=%b exp=%b", ctrl, c_LU); end
        expStall += 1; expFlush += 1;
        // Bubble now in E: the hazard is gone next cycle
        @(negedge clk); clear_inputs(); hzIf.Rs2D = 7; #1;
        tests++; if (ctrl !== c_NONE) begin fails++; $display("FAIL lu_once got=%b exp=%b", ctrl, c_NONE); end
        // Load to x0 never stalls
        hzIf.ResultSrcE = 1; hzIf.RegWriteE = 1; hzIf.RdE = 0; hzIf.Rs1D = 0; #1;
        tests++; if (ctrl !== c_NONE) begin fails++; $display("FAIL lu_x0 got=%b exp=%b", ctrl, c_NONE); end
    endtask

    task automatic test_branch();
        @(negedge clk); clear_inputs();
        hzIf.ResultSrcE = 1; hzIf.RegWriteE = 1; hzIf.RdE = 7; hzIf.Rs2D = 7; hzIf.PCSrcE = 1; #1;
        tests++; if (ctrl !== c_BR) begin fails++; $display("FAIL br_ctrl got=%b exp=%b", ctrl, c_BR); end
        expFlush += 1;
        // Branch also squashes a mul/div sitting in E
        @(negedge clk); clear_inputs(); hzIf.PCSrcE = 1; hzIf.MulDivE = 1; #1;
        tests++; if (ctrl !== c_BR) begin fails++; $display("FAIL br_md got=%b exp=%b", ctrl, c_BR); end
        expFlush += 1;
        @(negedge clk); clear_inputs(); #1;
        tests++; if (ctrl !== c_NONE) begin fails++; $display("FAIL br_after got=%b exp=%b", ctrl, c_NONE); end
    endtask

    task automatic test_perf_counters();
        @(negedge clk); clear_inputs(); #1;
`ifdef HAZARD_PERF_CNT_EN
        tests++; if (hzIf.StallCnt !== expStall) begin fails++; $display("FAIL cnt_stall got=%0d exp=%0d", hzIf.StallCnt, expStall); end
        tests++; if (hzIf.FlushCnt !== expFlush) begin fails++; $display("FAIL cnt_flush got=%0d exp=%0d", hzIf.FlushCnt, expFlush); end
`else
        tests++; if (hzIf.StallCnt !== '0) begin fails++; $display("FAIL cnt_stall_tie got=%0d exp=0", hzIf.StallCnt); end
        tests++; if (hzIf.FlushCnt !== '0) begin fails++; $display("FAIL cnt_flush_tie got=%0d exp=0", hzIf.FlushCnt); end
`endif
    endtask

    task automatic test_muldiv();
        int stallCycles = 0;
        // MdDone while idle does nothing
        @(negedge clk); clear_inputs(); hzIf.MdDone = 1; #1;
        tests++; if (ctrl !== c_NONE) begin fails++; $display("FAIL md_idle_done got=%b exp=%b", ctrl, c_NONE); end
        // Issue, with a coincident load-use that must not flush E
        @(negedge clk); clear_inputs(); hzIf.MulDivE = 1;
        hzIf.ResultSrcE = 1; hzIf.RegWriteE = 1; hzIf.RdE = 7; hzIf.Rs1D = 7; #1;
        tests++; if (ctrl !== c_START) begin fails++; $display("FAIL md_start got=%b exp=%b", ctrl, c_START); end
        if (ctrl[7]) stallCycles++;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk); hzIf.PCSrcE = (i == 2); #1;
            tests++; if (ctrl !== c_BUSY) begin fails++; $display("FAIL md_busy%0d got=%b exp=%b", i, ctrl, c_BUSY); end
            if (ctrl[7]) stallCycles++;
        end
        @(negedge clk); hzIf.PCSrcE = 0; hzIf.MdDone = 1; #1;
        tests++; if (ctrl !== c_REL) begin fails++; $display("FAIL md_done got=%b exp=%b", ctrl, c_REL); end
        tests++; if (stallCycles != 4) begin fails++; $display("FAIL md_stall_len got=%0d exp=4", stallCycles); end
        expStall += 4;
        @(negedge clk); clear_inputs(); #1;
        tests++; if (ctrl !== c_NONE || hzIf.MdError !== 1'b0) begin fails++; $display("FAIL md_idle got=%b err=%b exp=%b err=0", ctrl, hzIf.MdError, c_NONE); end
    endtask

    task automatic test_back_to_back();
        @(negedge clk); clear_inputs(); hzIf.MulDivE = 1; #1;
        tests++; if (ctrl !== c_START) begin fails++; $display("FAIL b2b_start1 got=%b exp=%b", ctrl, c_START); end
        @(negedge clk); hzIf.MdDone = 1; #1;
        tests++; if (ctrl !== c_REL) begin fails++; $display("FAIL b2b_done1 got=%b exp=%b", ctrl, c_REL); end
        @(negedge clk); hzIf.MdDone = 0; #1;
        tests++; if (ctrl !== c_START) begin fails++; $display("FAIL b2b_start2 got=%b exp=%b", ctrl, c_START); end
        @(negedge clk); hzIf.MdDone = 1; #1;
        tests++; if (ctrl !== c_REL) begin fails++; $display("FAIL b2b_done2 got=%b exp=%b", ctrl, c_REL); end
        expStall += 2;
        @(negedge clk); clear_inputs(); #1;
        tests++; if (ctrl !== c_NONE) begin fails++; $display("FAIL b2b_idle got=%b exp=%b", ctrl, c_NONE); end
    endtask

    // withDone: MdDone arrives exactly on the timeout cycle
    task automatic test_timeout(input logic withDone);
        int stallCycles = 0;
        @(negedge clk); clear_inputs(); hzIf.MulDivE = 1; #1;
        if (ctrl[7]) stallCycles++;
        for (int i = 1; i < MD_TIMEOUT; i++) begin
            @(negedge clk); hzIf.MulDivE = 0; #1;
            if (ctrl[7]) stallCycles++;
        end
        @(negedge clk); hzIf.MdDone = withDone; #1;
        tests++; if (ctrl !== c_REL) begin fails++; $display("FAIL to_release(d=%b) got=%b exp=%b", withDone, ctrl, c_REL); end
        tests++; if (stallCycles != MD_TIMEOUT) begin fails++; $display("FAIL to_len(d=%b) got=%0d exp=%0d", withDone, stallCycles, MD_TIMEOUT); end
        expStall += CNT_W'(MD_TIMEOUT);
        @(negedge clk); clear_inputs(); #1;
        tests++; if (hzIf.MdError !== !withDone) begin fails++; $display("FAIL to_err(d=%b) got=%b exp=%b", withDone, hzIf.MdError, !withDone); end
        tests++; if (ctrl !== c_NONE) begin fails++; $display("FAIL to_idle(d=%b) got=%b exp=%b", withDone, ctrl, c_NONE); end
        repeat (3) @(negedge clk);
        #1;
        tests++; if (hzIf.MdError !== !withDone) begin fails++; $display("FAIL to_sticky(d=%b) got=%b exp=%b", withDone, hzIf.MdError, !withDone); end
    endtask

    task automatic test_reset_busy();
        @(negedge clk); clear_inputs(); hzIf.MulDivE = 1; #1;
        tests++; if (ctrl !== c_START) begin fails++; $display("FAIL rb_start got=%b exp=%b", ctrl, c_START); end
        @(negedge clk); hzIf.MulDivE = 0;
        @(negedge clk); rst = 1'b0; #1;
        tests++; if (ctrl !== c_NONE || hzIf.MdError !== 1'b0) begin fails++; $display("FAIL rb_outs got=%b err=%b exp=%b err=0", ctrl, hzIf.MdError, c_NONE); end
        tests++; if (hzIf.StallCnt !== '0 || hzIf.FlushCnt !== '0) begin fails++; $display("FAIL rb_cnt got=%0d/%0d exp=0/0", hzIf.StallCnt, hzIf.FlushCnt); end
        expStall = '0; expFlush = '0;
        @(negedge clk); rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); #1;
            tests++; if (ctrl !== c_NONE) begin fails++; $display("FAIL rb_nostart%0d got=%b exp=%b", i, ctrl, c_NONE); end
        end
        @(negedge clk); hzIf.MulDivE = 1; #1;
        tests++; if (ctrl !== c_START) begin fails++; $display("FAIL rb_restart got=%b exp=%b", ctrl, c_START); end
        @(negedge clk); hzIf.MulDivE = 0; hzIf.MdDone = 1; #1;
        tests++; if (ctrl !== c_REL) begin fails++; $display("FAIL rb_done got=%b exp=%b", ctrl, c_REL); end
        expStall += 1;
    endtask

    initial begin
        test_reset();
        test_forward();
        test_load_use();
        test_branch();
        test_perf_counters();
        test_muldiv();
        test_back_to_back();
        test_timeout(1'b1);
        test_timeout(1'b0);
        test_perf_counters();
        test_reset_busy();
        test_perf_counters();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hazard_control_unit.md
Name: hazard_control_unit

Overview:
Central hazard controller for the 5-stage RISC-V pipeline.
- Drives the execute-stage forwarding selects (ForwardA_E/ForwardB_E).
- Detects load-use hazards and stalls fetch/decode.
- Flushes decode/execute on taken branches.
- Sequences an external multi-cycle mul/div unit, freezing the front of the pipe through an IDLE/BUSY state machine with a timeout guard.

Parameters:
MD_TIMEOUT, 64, maximum BUSY cycles before the mul/div op is aborted (minimum 2).
CNT_W, 32, width of the performance counters.

Ports:
clk  input  1  pipeline clock, rising edge
rst  input  1  asynchronous reset, active-low
Rs1D, Rs2D  input  5  decode-stage source registers
Rs1E, Rs2E, RdE  input  5  execute-stage sources and destination
RdM, RdW  input  5  memory- and writeback-stage destinations
RegWriteE, RegWriteM, RegWriteW  input  1  register-write enables per stage
ResultSrcE  input  1  1 = execute-stage instruction is a load
PCSrcE  input  1  branch/jump taken in execute
MulDivE  input  1  execute-stage instruction is a multi-cycle mul/div
MdDone  input  1  mul/div unit result valid (one-cycle pulse)
ForwardA_E, ForwardB_E  output  2  00 = register file, 01 = ResultW, 10 = ALUResultM
StallF, StallD, StallE  output  1  hold the PC, IF/ID and ID/EX registers
FlushD, FlushE  output  1  clear IF/ID and ID/EX to a bubble
BubbleM  output  1  insert a bubble into EX/MEM
MdStart  output  1  one-cycle start pulse to the mul/div unit (operands latched by the unit)
MdBusy  output  1  FSM is in BUSY
MdError  output  1  sticky timeout flag
StallCnt, FlushCnt  output  CNT_W  performance counters

Behaviour:
- Reset (rst=0, async): FSM=IDLE, timeout counter=0, MdError=0, counters=0. All outputs are 0 while reset is held, including ForwardA_E/ForwardB_E=00.
- Forwarding (combinational, zero latency), stated for A; B is identical using Rs2E:
  - 10 if RegWriteM & RdM!=0 & RdM==Rs1E.
  - else 01 if RegWriteW & RdW!=0 & RdW==Rs1E.
  - else 00.
  - The M stage has priority over the W stage. x0 is never forwarded.
- Load-use: lwStall = ResultSrcE & RegWriteE & RdE!=0 & (RdE==Rs1D | RdE==Rs2D).
  - Effect: StallF=StallD=1 and FlushE=1 in the same cycle. Lasts exactly one cycle per occurrence.
- Branch: in IDLE, PCSrcE=1 gives FlushD=FlushE=1.
  - Branch overrides lwStall: StallF/StallD=0 because the dependent instruction is flushed.
- FSM IDLE:
  - MulDivE=1 & PCSrcE=0: MdStart=1; StallF=StallD=StallE=1; BubbleM=1; next state BUSY; timeout counter cleared.
  - lwStall in the same cycle is irrelevant because the front end is already stalled; FlushE=0.
- FSM BUSY:
  - MdBusy=1. StallF/StallD/StallE=1, BubbleM=1. PCSrcE and lwStall are ignored. Timeout counter increments each cycle.
  - MdDone=1: stalls and BubbleM drop this cycle, so the result advances to M at the next edge; next state IDLE.
  - Counter reaches MD_TIMEOUT-1 without MdDone: MdError set (sticky until reset), stalls released, next state IDLE.
  - MdDone on the same cycle as the timeout is treated as done; MdError is not set.
- MdDone while IDLE is ignored.
- MdStart is never asserted in BUSY, so back-to-back mul/div ops have at least one IDLE cycle between them.
- Reset mid-BUSY returns to IDLE immediately. No MdStart is issued after reset until a new MulDivE.

Optional Feature:
Macro HAZARD_PERF_CNT_EN.
- Defined:
  - StallCnt increments every cycle StallF=1.
  - FlushCnt increments every cycle FlushD|FlushE=1.
  - Both saturate at all-ones and clear only on reset.
- Undefined: the ports remain, both counters are tied to 0 and no counter logic is generated.

Test Plan:
- Forward priority: RdM=RdW=Rs1E=5, RegWriteM=RegWriteW=1 -> ForwardA_E=10. Drop RegWriteM -> 01. Set Rs1E=RdM=RdW=0 -> 00.
- Load-use: ResultSrcE=RegWriteE=1, RdE=7, Rs2D=7 -> StallF=StallD=FlushE=1 for one cycle; StallCnt +1 with HAZARD_PERF_CNT_EN.
- Branch vs load-use: same setup as load-use plus PCSrcE=1 -> FlushD=FlushE=1, StallF=StallD=0; FlushCnt +1.
- Mul/div: MulDivE=1, MdDone 3 cycles after MdStart -> MdStart high for 1 cycle; stalls high 4 cycles, releasing on the MdDone cycle; FSM returns to IDLE; MdError=0.
- Timeout: MD_TIMEOUT=8, MdDone never -> stalls release after 8 cycles, MdError=1 and stays 1 until rst=0.
- Reset in BUSY: drop rst two cycles after MdStart -> all outputs 0 immediately; after release FSM is IDLE and no MdStart occurs until MulDivE is reasserted.
